uart_tx_queue: RTL

Byte queue between the core's memory-mapped UART write port and the `uart_tx` serializer. It accepts single-byte writes from the memory/MMIO side into a power-of-two ring buffer. A small drain state machine then hands the bytes one at a time to `uart_tx` over its `start`/`data`/`ready` handshake. It replaces ad-hoc index polling with explicit full/empty/overflow status readable by software.

---
 rtl/uart_tx_queue_if.sv | 26 ++
 rtl/uart_tx_queue.sv | 111 +++++++++++
 2 files changed

// File: rtl/uart_tx_queue_if.sv
// Write-port / status / uart_tx handshake bundle for uart_tx_queue.
// The queue is the slave; the MMIO side plus the uart_tx serializer form the master.
interface uart_tx_queue_if #(
  parameter int PTR_W = 5
);
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             clr_overflow;
  logic             full;
  logic             empty;
  logic [PTR_W:0]   count;
  logic             overflow;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_ready;

  modport slave (
    input  wr_en, wr_data, clr_overflow, tx_ready,
    output full, empty, count, overflow, tx_start, tx_data
  );

  modport master (
    output wr_en, wr_data, clr_overflow, tx_ready,
    input  full, empty, count, overflow, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_queue.sv
// Byte ring buffer between the MMIO UART write port and uart_tx, with a drain FSM
// that issues one start pulse per byte and sticky overflow status.
module uart_tx_queue #(
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int GUARD = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_queue_if.slave bus
);
  localparam int CW = PTR_W + 1;
  localparam int GW = $clog2(GUARD) + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          ovf_q, ovf_d;
  logic          start_q, start_d;
  logic [7:0]    data_q, data_d;
  state_e        state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic          push, pop;

  // Acceptance uses the registered full flag, so a pop in the same cycle never frees room.
  always_comb begin
    push      = bus.wr_en && !full_q;
    pop       = (state_q == IDLE) && !empty_q && bus.tx_ready;
    wr_ptr_d  = wr_ptr_q + CW'(push);
    rd_ptr_d  = rd_ptr_q + CW'(pop);
    count_d   = wr_ptr_d - rd_ptr_d;
    full_d    = (count_d == CW'(DEPTH));
    empty_d   = (count_d == '0);
    ovf_d     = (bus.wr_en && full_q) || (ovf_q && !bus.clr_overflow);
  end

  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    data_d  = data_q;
    guard_d = guard_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          data_d  = mem_q[rd_ptr_q[PTR_W-1:0]];
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        guard_d = '0;
        state_d = WAIT_BUSY;
      end
      // A uart_tx that never drops ready is assumed to have taken the byte.
      WAIT_BUSY: begin
        if (!bus.tx_ready) begin
          state_d = WAIT_DONE;
        end else begin
          guard_d = guard_q + 1'b1;
          if (guard_d == GW'(GUARD - 1)) state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      start_q  <= 1'b0;
      data_q   <= '0;
      state_q  <= IDLE;
      guard_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      start_q  <= start_d;
      data_q   <= data_d;
      state_q  <= state_d;
      guard_q  <= guard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= bus.wr_data;
  end

  assign bus.full     = full_q;
  assign bus.empty    = empty_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;
  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;
endmodule
